fp16_result_collector: RTL and testbench

// - Downstream of the fp16 adder: tracks issued operand pairs and samples the adder's sum LAT cycles after issue.
// - Classifies each sampled result (NaN/Inf/zero/subnormal/sign).
// - Buffers results in a small FIFO with a valid/ready output.
// - Provides issue_ready credit back-pressure so the operand source never over-issues.

---
 rtl/fp16_pkg.sv | 42 ++++
 rtl/fp16_res_fifo.sv | 62 ++++++
 rtl/fp16_result_collector.sv | 113 +++++++++++
 tb/tb_fp16_result_collector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pkg
// Description : Shared fp16 field positions, result-flag type and the
//               classifier used when an adder result is captured.
// Revision    : 1.0  initial release
// ============================================================================
package fp16_pkg;

  localparam logic [4:0] FP16_EXP_MAX  = 5'h1F;
  localparam int         FP16_SIGN_BIT = 15;
  localparam int         FP16_EXP_MSB  = 14;
  localparam int         FP16_EXP_LSB  = 10;
  localparam int         FP16_MAN_MSB  = 9;
  localparam int         FP16_MAN_LSB  = 0;
  localparam int         FP16_FLAGS_W  = 5;

  // Packed so that the vector form reads {nan, inf, zero, sub, neg}
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sub;
    logic neg;
  } fp16_flags_t;

  function automatic fp16_flags_t fp16_classify(input logic [15:0] sum);
    logic [4:0]  exp_f;
    logic [9:0]  man_f;
    fp16_flags_t f;
    exp_f  = sum[FP16_EXP_MSB:FP16_EXP_LSB];
    man_f  = sum[FP16_MAN_MSB:FP16_MAN_LSB];
    f.nan  = (exp_f == FP16_EXP_MAX) && (man_f != '0);
    f.inf  = (exp_f == FP16_EXP_MAX) && (man_f == '0);
    f.zero = (exp_f == '0) && (man_f == '0);
    f.sub  = (exp_f == '0) && (man_f != '0);
    f.neg  = sum[FP16_SIGN_BIT];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fp16_res_fifo
// Description : Single-clock result FIFO (DEPTH x W) with occupancy count.
//               Pointers wrap naturally; count is one bit wider than them.
// Revision    : 1.0  initial release
// ============================================================================
module fp16_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;

  // Popping an empty FIFO is meaningless; ignore it
  assign w_do_pop = i_pop && (r_count != '0);

  // Storage array; cleared on reset so the head reads zero when idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fp16_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : fp16_result_collector
// Description : Tracks operand pairs issued to the fp16 adder, captures the
//               sum LAT edges later, classifies it and buffers it in a FIFO
//               with a valid/ready output. Credit-based issue_ready keeps
//               FIFO entries plus in-flight results within DEPTH.
//               Optional macro STICKY_FLAGS_EN adds sticky_flags/sticky_clr.
// Revision    : 1.0  initial release
// ============================================================================
module fp16_result_collector
  import fp16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        issue,
  output logic        issue_ready,
  input  logic [15:0] sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [4:0]  out_flags,
  output logic        drop_err
`ifdef STICKY_FLAGS_EN
  ,
  output logic [4:0]  sticky_flags,
  input  logic        sticky_clr
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + LAT) + 1;
  localparam int FIFO_W = FP16_FLAGS_W + 16;

  logic [LAT-1:0]    r_vpipe;
  logic              r_drop;
  logic [CW-1:0]     w_inflight;
  logic [CW-1:0]     w_used;
  logic              w_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  fp16_flags_t       w_flags;
  logic [FIFO_W-1:0] w_rdata;
  logic [AW:0]       w_fifo_count;

  // Credit: every accepted issue holds one slot until its result is popped
  assign w_used      = CW'(w_fifo_count) + w_inflight;
  assign w_ready     = w_used < CW'(DEPTH);
  assign w_accept    = issue && w_ready;
  assign w_push      = r_vpipe[LAT-1];
  assign w_pop       = out_valid && out_ready;
  assign w_flags     = fp16_classify(sum);
  assign issue_ready = w_ready;

  // Count results still travelling through the adder
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + CW'(r_vpipe[i]);
  end

  // In-flight valid shift register; the tail marks the capture edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_vpipe <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) r_vpipe[i] <= r_vpipe[i-1];
      r_vpipe[0] <= w_accept;
    end
  end

  // One-cycle pulse for an issue made without credit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_drop <= 1'b0;
    else       r_drop <= issue && !w_ready;
  end

  fp16_res_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({w_flags, sum}),
    .o_rdata (w_rdata),
    .o_count (w_fifo_count)
  );

  assign out_valid = (w_fifo_count != '0);
  assign out_data  = w_rdata[15:0];
  assign out_flags = w_rdata[FIFO_W-1 -: FP16_FLAGS_W];
  assign drop_err  = r_drop;

`ifdef STICKY_FLAGS_EN
  logic [4:0] r_sticky;

  // Accumulate captured flags; a clear wins over a same-edge capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)           r_sticky <= '0;
    else if (sticky_clr) r_sticky <= '0;
    else if (w_push)     r_sticky <= r_sticky | w_flags;
  end

  assign sticky_flags = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_result_collector
// Description : Self-checking bench for fp16_result_collector. A queue-based
//               reference model tracks pending adder results and buffered
//               results; the adder is modelled as a fixed LAT-edge delay.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp16_result_collector;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        issue;
  logic        issue_ready;
  logic [15:0] sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_flags;
  logic        drop_err;
`ifdef STICKY_FLAGS_EN
  logic [4:0]  sticky_flags;
  logic        sticky_clr;
`endif

  fp16_result_collector #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .issue        (issue),
    .issue_ready  (issue_ready),
    .sum          (sum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .drop_err     (drop_err)
`ifdef STICKY_FLAGS_EN
    ,
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [15:0] val;
  } pend_t;

  pend_t       pq[$];
  logic [20:0] fq[$];
  int          cyc;
  logic        m_drop;
  logic [4:0]  m_sticky;
  int          n_cmp;
  int          n_bad;
  int          n_drop_seen;
  int          n_accept_seen;

  logic [15:0] specials [8] = '{16'h7C00, 16'h7E00, 16'h8000, 16'h0001,
                                16'h0000, 16'hFC00, 16'h83FF, 16'h59EC};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Flags from the fp16 field definitions, using plain arithmetic
  function automatic logic [4:0] ref_flags(input logic [15:0] v);
    int e, m;
    bit nan, inf, zero, sub, neg;
    e    = (int'(v) / 1024) % 32;
    m    = int'(v) % 1024;
    neg  = int'(v) >= 32768;
    nan  = (e == 31) && (m != 0);
    inf  = (e == 31) && (m == 0);
    zero = (e == 0) && (m == 0);
    sub  = (e == 0) && (m != 0);
    return {nan, inf, zero, sub, neg};
  endfunction

  function automatic bit m_ready();
    return (fq.size() + pq.size()) < DEPTH;
  endfunction

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(fq.size() > 0));
    if (fq.size() > 0) begin
      check("out_data", 32'(out_data), 32'(fq[0][15:0]));
      check("out_flags", 32'(out_flags), 32'(fq[0][20:16]));
    end
    check("issue_ready", 32'(issue_ready), 32'(m_ready()));
    check("drop_err", 32'(drop_err), 32'(m_drop));
    check("fifo_count", 32'(dut.u_fifo.r_count), 32'(fq.size()));
`ifdef STICKY_FLAGS_EN
    check("sticky", 32'(sticky_flags), 32'(m_sticky));
`endif
  endtask

  // One clock: drive inputs, advance the model across the edge, compare
  task automatic step(input bit iss, input bit ordy, input logic [15:0] val, input bit clr);
    bit          rdy, cap;
    logic [15:0] cv;
    rdy   = m_ready();
    issue = iss;
    out_ready = ordy;
`ifdef STICKY_FLAGS_EN
    sticky_clr = clr;
`endif
    cap = (pq.size() > 0) && (pq[0].due == cyc);
    cv  = cap ? pq[0].val : 16'($urandom);
    sum = cv;
    if (iss && issue_ready) n_accept_seen++;
    @(posedge CLK);
    if (ordy && fq.size() > 0) void'(fq.pop_front());
    if (cap) begin
      void'(pq.pop_front());
      fq.push_back({ref_flags(cv), cv});
    end
    check("no_overflow", 32'(fq.size() <= DEPTH), 32'd1);
    if (iss && rdy) pq.push_back('{cyc + LAT, val});
    m_drop = iss && !rdy;
    if (clr) m_sticky = '0;
    else if (cap) m_sticky = m_sticky | ref_flags(cv);
    cyc++;
    #1;
    if (drop_err) n_drop_seen++;
    compare_all();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    issue = 1'b0;
    out_ready = 1'b0;
`ifdef STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    pq.delete();
    fq.delete();
    m_drop   = 1'b0;
    m_sticky = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
`ifdef STICKY_FLAGS_EN
    check("rst_sticky", 32'(sticky_flags), 32'd0);
`endif
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] dir_val [5] = '{16'h59EC, 16'h7C00, 16'h7E00, 16'h8000, 16'h0001};
  logic [4:0]  dir_flg [5] = '{5'b00000, 5'b01000, 5'b10000, 5'b00101, 5'b00010};

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    n_drop_seen = 0; n_accept_seen = 0;
    sum = '0;
    do_reset();

    // Single results with fixed classification
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, dir_val[k], 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check("lat_early_valid", 32'(out_valid), 32'd0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check("dir_valid", 32'(out_valid), 32'd1);
      check("dir_data", 32'(out_data), 32'(dir_val[k]));
      check("dir_flags", 32'(out_flags), 32'(dir_flg[k]));
      step(1'b0, 1'b1, 16'h0, 1'b0);
    end

    // Fill with consumer stalled: 4 accepted, 5th dropped
    n_drop_seen = 0; n_accept_seen = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 16'h1000 + 16'(k), 1'b0);
      if (k == 3) check("ready_low_after_4", 32'(issue_ready), 32'd0);
    end
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0);
    check("fill_accepted", 32'(n_accept_seen), 32'd4);
    check("fill_drops", 32'(n_drop_seen), 32'd1);
    check("fill_head", 32'(out_data), 32'h1000);

    // Full FIFO drained while the source keeps issuing within credit
    n_drop_seen = 0;
    for (int k = 0; k < 20; k++)
      step(m_ready(), 1'b1, 16'h2000 + 16'(k), 1'b0);
    check("stream_drops", 32'(n_drop_seen), 32'd0);

    // Reset with two buffered and two in flight
    repeat (6) step(1'b0, 1'b1, 16'h0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'h3000 + 16'(k), 1'b0);
    check("pre_rst_buffered", 32'(dut.u_fifo.r_count), 32'd2);
    #2;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 16'h0, 1'b0);
      check("post_rst_empty", 32'(out_valid), 32'd0);
    end

`ifdef STICKY_FLAGS_EN
    step(1'b0, 1'b1, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h7C00, 1'b0);
    step(1'b1, 1'b1, 16'h8000, 1'b0);
    repeat (3) step(1'b0, 1'b1, 16'h0, 1'b0);
    check("sticky_accum", 32'(sticky_flags), 32'b01101);
    step(1'b1, 1'b1, 16'h0001, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b1);
    check("sticky_clr_prio", 32'(sticky_flags), 32'd0);
    repeat (2) step(1'b0, 1'b1, 16'h0, 1'b0);
`endif

    // Randomized traffic, including issues made without credit
    for (int k = 0; k < 400; k++) begin
      logic [15:0] v;
      v = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 16'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, v,
           $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
